data_bus_arbiter: RTL

Sequential 2-to-1 arbiter that shares the single SRAM-like data port toward the AXI wrapper between the dcache refill/writeback path (`ram_data_*`) and the uncached/config path (`conf_data_*`). It replaces steering by an external select with per-transaction ownership. Grants are round-robin. Outstanding transactions are tracked so that each `data_ok` is routed to the master that issued the request. The slave port is never switched while a request or a response is in flight.

---
 rtl/data_bus_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - round-robin 2:1 arbiter for the shared SRAM-like data port
module data_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ram_data_req,
    input  logic        ram_data_wr,
    input  logic [1:0]  ram_data_size,
    input  logic [31:0] ram_data_addr,
    input  logic [31:0] ram_data_wdata,
    output logic [31:0] ram_data_rdata,
    output logic        ram_data_addr_ok,
    output logic        ram_data_data_ok,
    input  logic        conf_data_req,
    input  logic        conf_data_wr,
    input  logic [1:0]  conf_data_size,
    input  logic [31:0] conf_data_addr,
    input  logic [31:0] conf_data_wdata,
    output logic [31:0] conf_data_rdata,
    output logic        conf_data_addr_ok,
    output logic        conf_data_data_ok,
    output logic        wrap_data_req,
    output logic        wrap_data_wr,
    output logic [1:0]  wrap_data_size,
    output logic [31:0] wrap_data_addr,
    output logic [31:0] wrap_data_wdata,
    input  logic [31:0] wrap_data_rdata,
    input  logic        wrap_data_addr_ok,
    input  logic        wrap_data_data_ok
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    // IDLE: port follows the live pick; OWNED: port locked to owner_q
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_q, last_d;

    logic        pick;
    logic        sel;
    logic        sel_req;
    logic        accept;
    logic        retire;

    // Round-robin pick: a tie goes to the master not granted last
    always_comb begin
        pick = 1'b0;
        if (ram_data_req && conf_data_req) begin
            pick = ~last_q;
        end else if (conf_data_req) begin
            pick = 1'b1;
        end
    end

    assign sel     = (state_q == OWNED) ? owner_q : pick;
    assign sel_req = sel ? conf_data_req : ram_data_req;

    assign wrap_data_req   = sel_req && (cnt_q < MAX_CNT);
    assign wrap_data_wr    = sel ? conf_data_wr    : ram_data_wr;
    assign wrap_data_size  = sel ? conf_data_size  : ram_data_size;
    assign wrap_data_addr  = sel ? conf_data_addr  : ram_data_addr;
    assign wrap_data_wdata = sel ? conf_data_wdata : ram_data_wdata;

    assign accept = wrap_data_req && wrap_data_addr_ok;
    // A data_ok with nothing outstanding is a slave protocol error and is dropped
    assign retire = wrap_data_data_ok && (cnt_q != 2'd0);

    assign ram_data_addr_ok  = accept && !sel;
    assign conf_data_addr_ok = accept && sel;

    assign ram_data_data_ok  = retire && !owner_q;
    assign conf_data_data_ok = retire && owner_q;
    assign ram_data_rdata    = (retire && !owner_q) ? wrap_data_rdata : 32'd0;
    assign conf_data_rdata   = (retire && owner_q)  ? wrap_data_rdata : 32'd0;

    // Next state: stay owned while anything is in flight or a forwarded request is still waiting
    always_comb begin
        cnt_d   = cnt_q + {1'b0, accept} - {1'b0, retire};
        state_d = ((cnt_d != 2'd0) || (wrap_data_req && !wrap_data_addr_ok)) ? OWNED : IDLE;
        owner_d = (state_q == OWNED) ? owner_q : pick;
        last_d  = accept ? sel : last_q;
    end

    // State registers; last_q resets to conf so the first tie goes to ram
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            cnt_q   <= 2'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule
